udp_tx_framer: RTL and testbench
================================

// Module: udp_tx_framer
// PURPOSE
//  Upstream stage of the UDP TX path: turns a free-running DATA_W sample stream into fixed-size packets.
//  Each packet is one header word, PAYLOAD_WORDS data words, and an optional trailer word.
//  A packet is zero-padded to full length if input stalls mid-packet.
//  Output is AXI-Stream (data/valid/ready/last) and feeds the TX path's din_* port in the sys_clk domain.
// PARAMETERS
//  DATA_W         64       word width; must be a multiple of 8 and >= 64
//  PAYLOAD_WORDS  128      data words per packet, 1..4095
//  FIFO_AW        4        input FIFO address bits (depth 2**FIFO_AW)
//  TIMEOUT_CYC    1024     consecutive empty-FIFO cycles in DATA before padding starts, >= 1
//  MAGIC          16'hA55A header sync pattern
// PORTS
//  sys_clk    in   1       clock
//  sys_rst_n  in   1       reset, asynchronous assert, active-low
//  enable     in   1       start new packets while high
//  s_data     in   DATA_W  sample in
//  s_valid    in   1       sample valid
//  s_ready    out  1       high = FIFO not full
//  m_data     out  DATA_W  packet word out
//  m_valid    out  1       packet word valid
//  m_last     out  1       last word of the packet
//  m_ready    in   1       downstream accept
//  seq_num    out  16      sequence number of the next packet to be started
//  pkt_done   out  1       1-cycle pulse when the last word is accepted
//  pad_cnt    out  16      total padded words since reset; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): FSM=IDLE; s_ready, m_valid, m_last, pkt_done = 0; m_data, seq_num, pad_cnt = 0; FIFO emptied.
//  Handshakes:
//   - Input transfer happens on s_valid & s_ready; output transfer on m_valid & m_ready.
//   - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
//  s_ready = !fifo_full, registered. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
//  FSM states: IDLE, HDR, DATA, PAD, TRL.
//   - IDLE -> HDR when enable=1 and the FIFO is non-empty.
//   - HDR: m_valid=1. m_data[63:0] = {MAGIC, seq_num, PAYLOAD_WORDS[15:0], 16'h0}. Bit 0 of that word = 1 if trailer is compiled in.
//     Bits [DATA_W-1:64] = 0. On handshake -> DATA and wcnt=0.
//   - DATA: m_valid = fifo_non_empty and m_data = FIFO head (first-word fall-through). Each handshake pops the FIFO and increments wcnt.
//     The idle timer counts cycles with the FIFO empty and clears on any pop.
//     When the timer reaches TIMEOUT_CYC -> PAD.
//   - PAD: m_valid=1, m_data=0. Each handshake increments wcnt and pad_cnt. FIFO data is ignored until the next packet.
//   - The word with wcnt == PAYLOAD_WORDS-1, in DATA or PAD, is the final payload word:
//     - trailer off: m_last=1 on that word; on accept -> IDLE, seq_num++, pkt_done=1.
//     - trailer on: -> TRL on accept.
//  seq_num wraps 16'hFFFF -> 0.
//  Header to first data word: 0 bubble cycles if the FIFO is non-empty.
//  Back-to-back packets: exactly one IDLE cycle between m_last accept and the next header.
//  enable dropped mid-packet: the packet completes normally; no new packet starts until enable=1.
//  A timeout on the very last payload word pads that single word.
// CONFIGURATION
//  Macro UDP_TX_FRAMER_TRAILER_EN.
//   Defined:
//   - extra state TRL; m_valid=1, m_last=1.
//   - m_data = XOR of all PAYLOAD_WORDS payload words of this packet, padded zeros included.
//   - The XOR accumulator clears in HDR.
//   - pkt_done fires on the TRL accept. Packet length = PAYLOAD_WORDS+2.
//   Undefined: no TRL state and no accumulator; header bit 0 = 0; packet length = PAYLOAD_WORDS+1.
// STRUCTURE
//  Shared package udp_pkg holds:
//   - FSM state encodings (3-bit);
//   - header field offsets (MAGIC_LSB=48, SEQ_LSB=32, LEN_LSB=16, FLAG_TRL=0);
//   - default MAGIC.
//  One sub-module: udp_tx_framer_fifo. It is a synchronous first-word-fall-through FIFO, DATA_W x 2**FIFO_AW, with registered full/empty.
//  Top level holds the FSM, wcnt, idle timer, seq/pad counters and the XOR accumulator.
// TESTING
//  T1 PAYLOAD_WORDS=4, stream 0x1..0x8, m_ready=1
//     -> two packets. Headers 0xA55A_0000_0004_000x then 0xA55A_0001_0004_000x.
//     -> m_last on data 0x4 / 0x8 (or on the trailers), seq_num=2, pkt_done twice.
//  T2 Feed 2 words then stop, TIMEOUT_CYC=8
//     -> after 8 empty cycles, 2 zero words padded, m_last on the 4th payload word, pad_cnt=2.
//  T3 m_ready toggled randomly at 50% while s_valid is held high
//     -> no word lost or duplicated; m_data stable while stalled; s_ready=0 once 16 words are queued.
//  T4 enable=0 asserted during word 2 of 4
//     -> packet finishes with m_last; no further header until enable=1.
//  T5 sys_rst_n pulsed low mid-DATA
//     -> outputs 0 immediately (async). After release, the first header carries seq 0 and the FIFO is empty.
//  T6 Trailer build, payload 0x1,0x2,0x4,0x8 -> trailer word 0xF with m_last; header bit 0=1.

Source files
------------

// File: rtl/udp_tx_framer_pkg.sv
// Shared definitions for the UDP TX framer: FSM encodings, header field offsets, default sync pattern.
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_TRL  = 3'd4
  } state_e;

  localparam int MAGIC_LSB = 48;
  localparam int SEQ_LSB   = 32;
  localparam int LEN_LSB   = 16;
  localparam int FLAG_TRL  = 0;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;

  // Assemble the 64-bit header word from its fields.
  function automatic logic [63:0] build_header(input logic [15:0] magic,
                                               input logic [15:0] seq,
                                               input logic [15:0] len,
                                               input logic        trl);
    logic [63:0] hdr;
    hdr                   = 64'h0;
    hdr[MAGIC_LSB +: 16]  = magic;
    hdr[SEQ_LSB +: 16]    = seq;
    hdr[LEN_LSB +: 16]    = len;
    hdr[FLAG_TRL]         = trl;
    return hdr;
  endfunction

endpackage

// File: rtl/udp_tx_framer_fifo.sv
// Synchronous first-word-fall-through FIFO, DATA_W x 2**AW, with registered full/empty flags.
// full_next exposes the next-cycle full flag so the parent can register its ready output.
module udp_tx_framer_fifo #(
  parameter int DATA_W = 64,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full_next
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok_s, pop_ok_s;

  // Pointer, occupancy and flag next-state.
  always_comb begin
    push_ok_s = push && !full_q;  // a full FIFO refuses the push even when popping
    pop_ok_s  = pop && !empty_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign full_next = full_d;

endmodule

// File: rtl/udp_tx_framer.sv
// Packetises a free-running sample stream into header + PAYLOAD_WORDS data words (+ optional XOR trailer).
// Optional trailer word is enabled by defining UDP_TX_FRAMER_TRAILER_EN.
module udp_tx_framer
  import udp_pkg::*;
#(
  parameter int          DATA_W        = 64,
  parameter int          PAYLOAD_WORDS = 128,
  parameter int          FIFO_AW       = 4,
  parameter int          TIMEOUT_CYC   = 1024,
  parameter logic [15:0] MAGIC         = MAGIC_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [15:0]       seq_num,
  output logic              pkt_done,
  output logic [15:0]       pad_cnt
);

  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [11:0] LAST_IDX = 12'(PAYLOAD_WORDS - 1);
`ifdef UDP_TX_FRAMER_TRAILER_EN
  localparam logic        TRL_FLAG = 1'b1;
`else
  localparam logic        TRL_FLAG = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              s_ready_q, s_ready_d;
  logic              pkt_done_q, pkt_done_d;
  logic [11:0]       wcnt_q, wcnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       pad_q, pad_d;
`ifdef UDP_TX_FRAMER_TRAILER_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  logic              fifo_push_s, fifo_pop_s;
  logic              fifo_empty_s, fifo_full_next_s;
  logic [DATA_W-1:0] fifo_rdata_s;
  logic [DATA_W-1:0] hdr_s;
  logic              accept_s, final_s, fetch_s, pay_done_s;
  logic [11:0]       fetch_idx_s;

  // Without a trailer the final payload word closes the packet.
  function automatic logic is_last_payload(input logic [11:0] idx);
    return (TRL_FLAG == 1'b0) && (idx == LAST_IDX);
  endfunction

  assign fifo_push_s = s_valid && s_ready_q;
  assign hdr_s       = DATA_W'(build_header(MAGIC, seq_q, 16'(PAYLOAD_WORDS), TRL_FLAG));

  udp_tx_framer_fifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (fifo_push_s),
    .wdata     (s_data),
    .pop       (fifo_pop_s),
    .rdata     (fifo_rdata_s),
    .empty     (fifo_empty_s),
    .full_next (fifo_full_next_s)
  );

  // FSM next-state: the output register always holds the word currently offered downstream.
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    wcnt_d      = wcnt_q;
    timer_d     = timer_q;
    seq_d       = seq_q;
    pad_d       = pad_q;
    pkt_done_d  = 1'b0;
    s_ready_d   = !fifo_full_next_s;
    fifo_pop_s  = 1'b0;
    fetch_s     = 1'b0;
    fetch_idx_s = wcnt_q;
    pay_done_s  = 1'b0;
`ifdef UDP_TX_FRAMER_TRAILER_EN
    acc_d       = acc_q;
`endif
    accept_s    = m_valid_q && m_ready;
    final_s     = (wcnt_q == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty_s) begin
          state_d   = ST_HDR;
          m_valid_d = 1'b1;
          m_data_d  = hdr_s;
          m_last_d  = 1'b0;
        end else begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          state_d     = ST_DATA;
          wcnt_d      = 12'd0;
          timer_d     = '0;
          fetch_s     = 1'b1;
          fetch_idx_s = 12'd0;
`ifdef UDP_TX_FRAMER_TRAILER_EN
          acc_d       = '0;
`endif
        end else begin
          m_valid_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
`ifdef UDP_TX_FRAMER_TRAILER_EN
          acc_d = acc_q ^ m_data_q;
`endif
          if (final_s) begin
            pay_done_s = 1'b1;
          end else begin
            wcnt_d      = wcnt_q + 12'd1;
            fetch_s     = 1'b1;
            fetch_idx_s = wcnt_q + 12'd1;
          end
        end else if (!m_valid_q) begin
          // Idle timer only runs while a payload slot is waiting on an empty FIFO.
          if (!fifo_empty_s) begin
            fetch_s = 1'b1;
          end else if (timer_q == TMO_LAST) begin
            state_d   = ST_PAD;
            m_valid_d = 1'b1;
            m_data_d  = '0;
            m_last_d  = is_last_payload(wcnt_q);
            timer_d   = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end else begin
          m_valid_d = 1'b1;
        end
      end
      ST_PAD: begin
        if (accept_s) begin
          if (pad_q != 16'hFFFF) begin
            pad_d = pad_q + 16'd1;
          end else begin
            pad_d = pad_q;
          end
          if (final_s) begin
            pay_done_s = 1'b1;
          end else begin
            wcnt_d   = wcnt_q + 12'd1;
            m_data_d = '0;
            m_last_d = is_last_payload(wcnt_q + 12'd1);
          end
        end else begin
          m_valid_d = 1'b1;
        end
      end
`ifdef UDP_TX_FRAMER_TRAILER_EN
      ST_TRL: begin
        if (accept_s) begin
          state_d    = ST_IDLE;
          m_valid_d  = 1'b0;
          m_last_d   = 1'b0;
          seq_d      = seq_q + 16'd1;
          pkt_done_d = 1'b1;
        end else begin
          m_valid_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    endcase

    if (fetch_s) begin
      if (!fifo_empty_s) begin
        m_valid_d  = 1'b1;
        m_data_d   = fifo_rdata_s;
        m_last_d   = is_last_payload(fetch_idx_s);
        fifo_pop_s = 1'b1;
        timer_d    = '0;
      end else begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    end else begin
      fifo_pop_s = 1'b0;
    end

    if (pay_done_s) begin
`ifdef UDP_TX_FRAMER_TRAILER_EN
      state_d    = ST_TRL;
      m_valid_d  = 1'b1;
      m_last_d   = 1'b1;
      m_data_d   = acc_d;
`else
      state_d    = ST_IDLE;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      seq_d      = seq_q + 16'd1;
      pkt_done_d = 1'b1;
`endif
    end else begin
      seq_d = seq_d;
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      s_ready_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      wcnt_q     <= 12'd0;
      timer_q    <= '0;
      seq_q      <= 16'd0;
      pad_q      <= 16'd0;
`ifdef UDP_TX_FRAMER_TRAILER_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      s_ready_q  <= s_ready_d;
      pkt_done_q <= pkt_done_d;
      wcnt_q     <= wcnt_d;
      timer_q    <= timer_d;
      seq_q      <= seq_d;
      pad_q      <= pad_d;
`ifdef UDP_TX_FRAMER_TRAILER_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign s_ready  = s_ready_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign seq_num  = seq_q;
  assign pkt_done = pkt_done_q;
  assign pad_cnt  = pad_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed self-checking bench for udp_tx_framer (PAYLOAD_WORDS=4, TIMEOUT_CYC=8, 16-deep FIFO).
module tb_udp_tx_framer;

`ifdef UDP_TX_FRAMER_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] seq_num;
  logic        pkt_done;
  logic [15:0] pad_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pkt_cnt  = 0;
  int stab_err = 0;

  logic [64:0] got[$];
  int          got_cyc[$];
  logic [64:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [64:0] prev_word  = '0;

  udp_tx_framer #(
    .DATA_W        (64),
    .PAYLOAD_WORDS (4),
    .FIFO_AW       (4),
    .TIMEOUT_CYC   (8),
    .MAGIC         (16'hA55A)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (enable),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .seq_num   (seq_num),
    .pkt_done  (pkt_done),
    .pad_cnt   (pad_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor: log accepted words, count pkt_done pulses, watch stall stability.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || ({m_last, m_data} !== prev_word))) stab_err++;
      if (m_valid && m_ready) begin
        got.push_back({m_last, m_data});
        got_cyc.push_back(cyc);
      end
      if (pkt_done) pkt_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  task automatic check(input string tag, input logic [64:0] got_v, input logic [64:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got_v, exp_v);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 64'h0;
    m_ready   = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    got.delete();
    got_cyc.delete();
    pkt_cnt = 0;
  endtask

  task automatic send(input logic [63:0] w);
    int n;
    n       = 0;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge sys_clk);
    while (!s_ready && n < 500) begin
      n++;
      @(negedge sys_clk);
    end
    if (!s_ready) check("send_timeout", 65'(s_ready), 65'd1);
    @(posedge sys_clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 500) begin
      @(negedge sys_clk);
      #1 k++;
    end
    if (got.size() < n) check("wait_words", 65'(got.size()), 65'(n));
  endtask

  task automatic expect_pkt(input logic [15:0] seq, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] d);
    logic [63:0] hdr;
    hdr = {16'hA55A, seq, 16'h0004, 15'h0, TRL};
    exp_q.push_back({1'b0, hdr});
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({!TRL, d});
    if (TRL) exp_q.push_back({1'b1, a ^ b ^ c ^ d});
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, 65'(got.size()), 65'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    int pushed;
    int base;
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 64'h0;
    m_ready   = 1'b0;
    #12;
    check("rst_m_valid", 65'(m_valid), 65'd0);
    check("rst_m_last", 65'(m_last), 65'd0);
    check("rst_s_ready", 65'(s_ready), 65'd0);
    check("rst_m_data", 65'(m_data), 65'd0);
    check("rst_seq", 65'(seq_num), 65'd0);
    check("rst_pad", 65'(pad_cnt), 65'd0);
    check("rst_pkt_done", 65'(pkt_done), 65'd0);

    // T1: two back-to-back packets from a continuous stream
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int w = 1; w <= 8; w++) send(64'(w));
    repeat (40) @(posedge sys_clk);
    #1;
    expect_pkt(16'd0, 64'h1, 64'h2, 64'h3, 64'h4);
    expect_pkt(16'd1, 64'h5, 64'h6, 64'h7, 64'h8);
    compare_stream("t1");
    check("t1_seq", 65'(seq_num), 65'd2);
    check("t1_pkt_done", 65'(pkt_cnt), 65'd2);
    check("t1_pad", 65'(pad_cnt), 65'd0);

    // T2: starvation after two words pads the rest of the packet
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    send(64'h11);
    send(64'h22);
    repeat (60) @(posedge sys_clk);
    #1;
    if (got.size() >= 4) check("t2_gap", 65'(got_cyc[3] - got_cyc[2]), 65'd9);
    else check("t2_gap_len", 65'(got.size()), 65'd4);
    expect_pkt(16'd0, 64'h11, 64'h22, 64'h0, 64'h0);
    compare_stream("t2");
    check("t2_pad", 65'(pad_cnt), 65'd2);
    check("t2_pkt_done", 65'(pkt_cnt), 65'd1);

    // T3: fill the FIFO under backpressure, then random m_ready
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b0;
    pushed  = 0;
    s_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      s_data = 64'(k);
      @(negedge sys_clk);
      if (!s_ready) break;
      pushed++;
      @(posedge sys_clk);
      #1;
    end
    check("t3_fill_count", 65'(pushed), 65'd16);
    check("t3_s_ready_full", 65'(s_ready), 65'd0);
    fork
      begin
        for (int w = 17; w <= 24; w++) send(64'(w));
      end
      begin
        repeat (300) begin
          @(posedge sys_clk);
          #1 m_ready = (($urandom & 32'd1) != 32'd0);
        end
      end
    join
    m_ready = 1'b1;
    repeat (40) @(posedge sys_clk);
    #1;
    for (int p = 0; p < 6; p++) begin
      base = 4 * p;
      expect_pkt(16'(p), 64'(base + 1), 64'(base + 2), 64'(base + 3), 64'(base + 4));
    end
    compare_stream("t3");
    check("t3_stable", 65'(stab_err), 65'd0);
    check("t3_seq", 65'(seq_num), 65'd6);

    // T4: enable dropped mid-packet
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    fork
      begin
        for (int w = 1; w <= 8; w++) send(64'(w));
      end
      begin
        wait_words(3);
        enable = 1'b0;
      end
    join
    repeat (40) @(posedge sys_clk);
    #1;
    check("t4_words_disabled", 65'(got.size()), TRL ? 65'd6 : 65'd5);
    check("t4_pkt_done", 65'(pkt_cnt), 65'd1);
    check("t4_m_valid_idle", 65'(m_valid), 65'd0);
    enable = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1;
    expect_pkt(16'd0, 64'h1, 64'h2, 64'h3, 64'h4);
    expect_pkt(16'd1, 64'h5, 64'h6, 64'h7, 64'h8);
    compare_stream("t4");

    // T5: asynchronous reset while a data word is stalled
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    fork
      begin
        for (int w = 1; w <= 6; w++) send(64'(w));
      end
      wait_words(TRL ? 8 : 7);
    join
    @(posedge sys_clk);
    #1 m_ready = 1'b0;
    #2;
    check("t5_pre_valid", 65'(m_valid), 65'd1);
    check("t5_pre_data", 65'(m_data), 65'h6);
    check("t5_pre_seq", 65'(seq_num), 65'd1);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 65'(m_valid), 65'd0);
    check("t5_rst_data", 65'(m_data), 65'd0);
    check("t5_rst_last", 65'(m_last), 65'd0);
    check("t5_rst_s_ready", 65'(s_ready), 65'd0);
    check("t5_rst_seq", 65'(seq_num), 65'd0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    got.delete();
    got_cyc.delete();
    pkt_cnt = 0;
    m_ready = 1'b1;
    for (int w = 0; w < 4; w++) send(64'h77 + 64'(w));
    repeat (30) @(posedge sys_clk);
    #1;
    expect_pkt(16'd0, 64'h77, 64'h78, 64'h79, 64'h7A);
    compare_stream("t5");

    // T6: trailer XOR over 1,2,4,8 (0xF) or plain last data word without trailer
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    send(64'h1);
    send(64'h2);
    send(64'h4);
    send(64'h8);
    repeat (30) @(posedge sys_clk);
    #1;
    if (got.size() > 0) begin
      check("t6_hdr_flag", 65'(got[0][0]), 65'(TRL));
      check("t6_last_word", got[got.size() - 1], TRL ? {1'b1, 64'hF} : {1'b1, 64'h8});
    end else begin
      check("t6_empty", 65'(got.size()), 65'd1);
    end
    check("t6_pkt_done", 65'(pkt_cnt), 65'd1);
    check("final_stable", 65'(stab_err), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
